ex_muldiv_unit: RTL and testbench
=================================

Name: ex_muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit that lives in the execute stage.
- Its result is muxed onto the EX/MEM ALU-result path, so it is the value the memory stage later sees as me_alu_out.
- It holds the pipeline with a stall output while it computes, then presents the result for exactly one cycle.
- Flush from branch/jump resolution aborts an in-flight operation.

Parameters:
- XLEN, 32, operand/result width. Only 32 is supported; the internal counter width is $clog2(XLEN).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- ex_md_valid  input  1  an M-extension instruction is in EX. Held high while ex_md_stall=1.
- ex_func3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- ex_rs1_data  input  32  forwarded rs1 operand (dividend / multiplicand).
- ex_rs2_data  input  32  forwarded rs2 operand (divisor / multiplier).
- ex_flush  input  1  kill the EX instruction. Takes priority over ex_md_valid.
- ex_md_stall  output  1  freeze PC/IF/ID/EX registers.
- ex_md_done  output  1  one-cycle pulse; ex_md_result is valid this cycle.
- ex_md_result  output  32  registered result, held until the next done.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- Reset: state=IDLE, counter=0, ex_md_result=0, ex_md_done=0. ex_md_stall is forced 0 while reset=1.
- Stall is combinational: ex_md_stall = ex_md_valid & ~ex_flush & (state!=DONE) & ~reset.
- State IDLE:
  - On valid & ~flush, latch func3 and operands. Magnitudes are taken per signedness: MULH both signed, MULHSU rs1 signed only, DIV/REM signed.
  - Latch the result sign: product sign = XOR of operand signs; quotient sign = XOR of operand signs; remainder sign = dividend sign.
  - Next state is CALC with counter=0.
- Special cases skip CALC and go IDLE->DONE directly, done in cycle 1:
  - Divisor 0: DIV/DIVU give 0xFFFFFFFF; REM/REMU give rs1.
  - Signed overflow (rs1=0x80000000, rs2=0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
- State CALC:
  - One step per cycle for 32 cycles (counter 0..31). At counter==31, next state is DONE.
  - Multiply: unsigned shift-add into a 64-bit accumulator.
  - Divide: restoring division on magnitudes. Each cycle shift {rem,quot} left 1, trial-subtract the divisor, and set the quotient LSB if the trial is non-negative.
- State DONE:
  - ex_md_done=1 and ex_md_stall=0, so the pipeline advances this cycle.
  - Sign fix-up (two's complement of the magnitude) is applied when the result is registered on the CALC->DONE edge.
  - Result select: MUL takes the low 32 bits; MULH/MULHSU/MULHU take the high 32; DIV/DIVU take the quotient; REM/REMU take the remainder.
  - Next state is IDLE. A valid in IDLE the following cycle is a new instruction (back-to-back allowed, no dead cycle beyond DONE).
- Latency, normal case: valid first seen in cycle 0; stall high in cycles 0..32; done in cycle 33.
- Flush:
  - In CALC or IDLE: next state is IDLE, no done pulse, ex_md_result unchanged.
  - In DONE: done still pulses, since the instruction has already retired to EX/MEM.
- If ex_md_valid drops in CALC without a flush (protocol violation), the operation completes and done pulses anyway.
- Reset mid-operation: returns to IDLE next edge, and all outputs take their reset values.
- Widths: all internal arithmetic is unsigned on 33/64-bit magnitudes. Abs(0x80000000) is 0x80000000 as unsigned, with no overflow.

Optional Feature:
- Macro: FAST_MUL_EN.
- Defined: MUL/MULH/MULHSU/MULHU compute combinationally from a 33x33 signed product, registered on IDLE->DONE. Done arrives in cycle 1 with a 1-cycle stall. Divides are unchanged.
- Undefined: all multiplies use the 32-cycle CALC path and give results identical to the defined build.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD (-3) -> stall cycles 0..32, done in cycle 33, result 0xFFFFFFEB. With FAST_MUL_EN: done in cycle 1, same result.
- MULHU 0xFFFFFFFF,0xFFFFFFFF -> 0xFFFFFFFE. MULH same operands -> 0x00000000. MULHSU 0xFFFFFFFF,0xFFFFFFFF -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD. REM -7/2 -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- DIVU 5/0 -> 0xFFFFFFFF, done in cycle 1. REM 5/0 -> 5. DIV 0x80000000/0xFFFFFFFF -> 0x80000000. REM same operands -> 0.
- DIV 100/7 with ex_flush=1 in cycle 10 -> stall drops that cycle, no done, result keeps its previous value, next DIV completes normally.
- Back-to-back MUL 3*4 then DIVU 9/2 with valid held high -> done pulses give 12 then 4, with the second done 34 cycles after the first. Reset asserted mid-CALC -> outputs 0, IDLE.

Source files
------------

// File: rtl/ex_muldiv_unit.sv
// rtl/ex_muldiv_unit.sv - iterative RV32M multiply/divide unit for the execute stage
// Build option FAST_MUL_EN: multiplies finish in one cycle from a combinational product;
// divides always use the 32-step restoring path.
module ex_muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ex_md_valid,
  input  logic [2:0]      ex_func3,
  input  logic [XLEN-1:0] ex_rs1_data,
  input  logic [XLEN-1:0] ex_rs2_data,
  input  logic            ex_flush,
  output logic            ex_md_stall,
  output logic            ex_md_done,
  output logic [XLEN-1:0] ex_md_result
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state, state_next;
  logic [CW-1:0]     counter, counter_next;
  logic [2:0]        func_q, func_next;
  logic [XLEN-1:0]   opnd_q, opnd_next;
  logic [2*XLEN-1:0] acc_q, acc_next;
  logic              neg_q, neg_next;
  logic [XLEN-1:0]   result_q, result_next;

  logic              is_div;
  logic              rs1_signed;
  logic              rs2_signed;
  logic              a_neg;
  logic              b_neg;
  logic              res_neg;
  logic              div_zero;
  logic              div_ovf;
  logic [XLEN-1:0]   a_mag;
  logic [XLEN-1:0]   b_mag;
  logic [XLEN-1:0]   special_res;

  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     rem_sh;
  logic [XLEN-1:0]   rem_diff;
  logic              quot_bit;
  logic [2*XLEN-1:0] acc_step;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quot_fix;
  logic [XLEN-1:0]   rem_fix;
  logic [XLEN-1:0]   calc_res;

  // Decode the incoming instruction: signedness, magnitudes, result sign, special cases
  always_comb begin
    is_div      = ex_func3[2];
    rs1_signed  = is_div ? ~ex_func3[0] : (ex_func3[1:0] == 2'b01 || ex_func3[1:0] == 2'b10);
    rs2_signed  = is_div ? ~ex_func3[0] : (ex_func3[1:0] == 2'b01);
    a_neg       = rs1_signed & ex_rs1_data[XLEN-1];
    b_neg       = rs2_signed & ex_rs2_data[XLEN-1];
    // abs(most-negative) wraps to itself, which is the correct unsigned magnitude
    a_mag       = a_neg ? -ex_rs1_data : ex_rs1_data;
    b_mag       = b_neg ? -ex_rs2_data : ex_rs2_data;
    // remainder follows the dividend; products and quotients follow the operand XOR
    res_neg     = (is_div && ex_func3[1]) ? a_neg : (a_neg ^ b_neg);
    div_zero    = is_div && (ex_rs2_data == '0);
    div_ovf     = is_div && !ex_func3[0] &&
                  (ex_rs1_data == {1'b1, {(XLEN-1){1'b0}}}) && (ex_rs2_data == '1);
    special_res = '0;
    if (div_zero) begin
      special_res = ex_func3[1] ? ex_rs1_data : '1;
    end else begin
      special_res = ex_func3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end
  end

  // One iteration of shift-add multiply or restoring divide, plus final sign fix-up
  always_comb begin
    // multiply: low half of acc holds the multiplier, consumed LSB first
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
    // divide: high half is the partial remainder, low half the dividend/quotient
    rem_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    quot_bit = (rem_sh >= {1'b0, opnd_q});
    rem_diff = rem_sh[XLEN-1:0] - opnd_q;
    if (func_q[2]) begin
      acc_step = {(quot_bit ? rem_diff : rem_sh[XLEN-1:0]), acc_q[XLEN-2:0], quot_bit};
    end else begin
      acc_step = {mul_sum, acc_q[XLEN-1:1]};
    end
    prod_fix = neg_q ? -acc_step : acc_step;
    quot_fix = neg_q ? -acc_step[XLEN-1:0] : acc_step[XLEN-1:0];
    rem_fix  = neg_q ? -acc_step[2*XLEN-1:XLEN] : acc_step[2*XLEN-1:XLEN];
    case (func_q)
      3'b000:                 calc_res = prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: calc_res = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         calc_res = quot_fix;
      default:                calc_res = rem_fix;
    endcase
  end

`ifdef FAST_MUL_EN
  logic [2*XLEN-1:0] fast_a;
  logic [2*XLEN-1:0] fast_b;
  logic [2*XLEN-1:0] fast_prod;
  logic [XLEN-1:0]   fast_res;

  // Single-cycle product of sign/zero-extended operands; low 64 bits are exact
  always_comb begin
    fast_a    = {{XLEN{a_neg}}, ex_rs1_data};
    fast_b    = {{XLEN{b_neg}}, ex_rs2_data};
    fast_prod = fast_a * fast_b;
    fast_res  = (ex_func3[1:0] == 2'b00) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
  end
`endif

  // Next-state and datapath-load logic
  always_comb begin
    state_next   = state;
    counter_next = counter;
    func_next    = func_q;
    opnd_next    = opnd_q;
    acc_next     = acc_q;
    neg_next     = neg_q;
    result_next  = result_q;
    case (state)
      IDLE: begin
        if (ex_md_valid && !ex_flush) begin
          func_next    = ex_func3;
          neg_next     = res_neg;
          counter_next = '0;
          if (div_zero || div_ovf) begin
            result_next = special_res;
            state_next  = DONE;
          end
`ifdef FAST_MUL_EN
          else if (!is_div) begin
            result_next = fast_res;
            state_next  = DONE;
          end
`endif
          else begin
            opnd_next  = is_div ? b_mag : a_mag;
            acc_next   = {{XLEN{1'b0}}, (is_div ? a_mag : b_mag)};
            state_next = CALC;
          end
        end
      end
      CALC: begin
        if (ex_flush) begin
          state_next   = IDLE;
          counter_next = '0;
        end else begin
          acc_next     = acc_step;
          counter_next = counter + CW'(1);
          if (counter == CW'(XLEN-1)) begin
            result_next  = calc_res;
            counter_next = '0;
            state_next   = DONE;
          end
        end
      end
      DONE: begin
        // the instruction has already left EX, so a flush here cannot cancel it
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      counter  <= '0;
      func_q   <= '0;
      opnd_q   <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state    <= state_next;
      counter  <= counter_next;
      func_q   <= func_next;
      opnd_q   <= opnd_next;
      acc_q    <= acc_next;
      neg_q    <= neg_next;
      result_q <= result_next;
    end
  end

  assign ex_md_stall  = ex_md_valid & ~ex_flush & (state != DONE) & ~reset;
  assign ex_md_done   = (state == DONE);
  assign ex_md_result = result_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb/tb_ex_muldiv_unit.sv - self-checking bench for ex_muldiv_unit
module tb_ex_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_md_valid;
  logic [2:0]  ex_func3;
  logic [31:0] ex_rs1_data;
  logic [31:0] ex_rs2_data;
  logic        ex_flush;
  logic        ex_md_stall;
  logic        ex_md_done;
  logic [31:0] ex_md_result;

  int checks = 0;
  int failures = 0;

`ifdef FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  ex_muldiv_unit #(.XLEN(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .ex_md_valid  (ex_md_valid),
    .ex_func3     (ex_func3),
    .ex_rs1_data  (ex_rs1_data),
    .ex_rs2_data  (ex_rs2_data),
    .ex_flush     (ex_flush),
    .ex_md_stall  (ex_md_stall),
    .ex_md_done   (ex_md_done),
    .ex_md_result (ex_md_result)
  );

  always #5 clk = ~clk;

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Architectural RV32M result, straight from the ISA rules
  function automatic logic [31:0] ref_md(input logic [2:0] f, input logic [31:0] a,
                                         input logic [31:0] b);
    longint sa, sb, ua, ub, p;
    logic [31:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    r  = 32'd0;
    case (f)
      3'd0: begin p = ua * ub; r = p[31:0]; end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * ub; r = p[63:32]; end
      3'd3: begin p = ua * ub; r = p[63:32]; end
      3'd4: begin
        if (b == 32'd0) r = 32'hFFFF_FFFF;
        else begin p = sa / sb; r = p[31:0]; end
      end
      3'd5: begin
        if (b == 32'd0) r = 32'hFFFF_FFFF;
        else begin p = ua / ub; r = p[31:0]; end
      end
      3'd6: begin
        if (b == 32'd0) r = a;
        else begin p = sa % sb; r = p[31:0]; end
      end
      default: begin
        if (b == 32'd0) r = a;
        else begin p = ua % ub; r = p[31:0]; end
      end
    endcase
    return r;
  endfunction

  function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (!f[2]) return MUL_LAT;
    if (b == 32'd0) return 1;
    if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Present an op at the start of a cycle and wait for done; returns at done's sample point
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output bit stall_ok);
    ex_md_valid = 1'b1;
    ex_func3    = f;
    ex_rs1_data = a;
    ex_rs2_data = b;
    lat         = -1;
    res         = 32'hx;
    stall_ok    = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (ex_md_done) begin
        lat = c;
        res = ex_md_result;
        if (ex_md_stall) stall_ok = 1'b0;
        break;
      end
      if (!ex_md_stall) stall_ok = 1'b0;
      next_cycle();
    end
  endtask

  initial begin
    logic [31:0] res;
    int          lat;
    int          lat2;
    bit          stall_ok;
    int          seen;
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;

    vecs[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT};
    vecs[1]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT};
    vecs[2]  = '{3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, MUL_LAT};
    vecs[3]  = '{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT};
    vecs[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33};
    vecs[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33};
    vecs[6]  = '{3'd5, 32'd100,        32'd7,         32'd14,        33};
    vecs[7]  = '{3'd7, 32'd100,        32'd7,         32'd2,         33};
    vecs[8]  = '{3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, 1};
    vecs[9]  = '{3'd6, 32'd5,          32'd0,         32'd5,         1};
    vecs[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1};
    vecs[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1};

    reset       = 1'b1;
    ex_md_valid = 1'b1;
    ex_func3    = 3'd0;
    ex_rs1_data = 32'd7;
    ex_rs2_data = 32'd3;
    ex_flush    = 1'b0;
    next_cycle();
    @(negedge clk);
    check32("reset_stall", {31'd0, ex_md_stall}, 32'd0);
    check32("reset_done", {31'd0, ex_md_done}, 32'd0);
    check32("reset_result", ex_md_result, 32'd0);
    next_cycle();
    reset       = 1'b0;
    ex_md_valid = 1'b0;
    next_cycle();

    // directed table
    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].f, vecs[i].a, vecs[i].b, res, lat, stall_ok);
      check32($sformatf("vec%0d_result", i), res, vecs[i].exp);
      check_int($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      check32($sformatf("vec%0d_stall", i), {31'd0, stall_ok}, 32'd1);
      next_cycle();
      ex_md_valid = 1'b0;
      next_cycle();
    end

    // flush mid-divide: no done, result keeps the earlier value
    run_op(3'd7, 32'd100, 32'd7, res, lat, stall_ok);
    check32("pre_flush_result", res, 32'd2);
    next_cycle();
    ex_md_valid = 1'b0;
    next_cycle();
    ex_md_valid = 1'b1;
    ex_func3    = 3'd4;
    ex_rs1_data = 32'd100;
    ex_rs2_data = 32'd7;
    repeat (10) next_cycle();
    ex_flush = 1'b1;
    @(negedge clk);
    check32("flush_stall_drop", {31'd0, ex_md_stall}, 32'd0);
    next_cycle();
    ex_flush    = 1'b0;
    ex_md_valid = 1'b0;
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (ex_md_done) seen++;
      next_cycle();
    end
    check_int("flush_no_done", seen, 0);
    check32("flush_result_held", ex_md_result, 32'd2);
    run_op(3'd4, 32'd100, 32'd7, res, lat, stall_ok);
    check32("after_flush_result", res, 32'd14);
    check_int("after_flush_latency", lat, 33);
    next_cycle();
    ex_md_valid = 1'b0;
    next_cycle();

    // valid dropped mid-CALC: the op still completes
    ex_md_valid = 1'b1;
    ex_func3    = 3'd7;
    ex_rs1_data = 32'd100;
    ex_rs2_data = 32'd7;
    repeat (3) next_cycle();
    ex_md_valid = 1'b0;
    lat = -1;
    for (int c = 3; c < 80; c++) begin
      @(negedge clk);
      if (ex_md_done) begin
        lat = c;
        break;
      end
      next_cycle();
    end
    check_int("valid_drop_latency", lat, 33);
    check32("valid_drop_result", ex_md_result, 32'd2);
    next_cycle();

    // back-to-back with valid held high
    run_op(3'd0, 32'd3, 32'd4, res, lat, stall_ok);
    check32("b2b_first_result", res, 32'd12);
    check_int("b2b_first_latency", lat, MUL_LAT);
    next_cycle();
    run_op(3'd5, 32'd9, 32'd2, res, lat2, stall_ok);
    check32("b2b_second_result", res, 32'd4);
    check_int("b2b_done_spacing", lat2 + 1, 34);
    next_cycle();

    // reset in the middle of a divide
    ex_func3    = 3'd5;
    ex_rs1_data = 32'd1000;
    ex_rs2_data = 32'd3;
    repeat (5) next_cycle();
    reset = 1'b1;
    @(negedge clk);
    check32("midreset_stall", {31'd0, ex_md_stall}, 32'd0);
    next_cycle();
    @(negedge clk);
    check32("midreset_result", ex_md_result, 32'd0);
    check32("midreset_done", {31'd0, ex_md_done}, 32'd0);
    next_cycle();
    reset       = 1'b0;
    ex_md_valid = 1'b0;
    next_cycle();
    run_op(3'd0, 32'd3, 32'd4, res, lat, stall_ok);
    check32("post_reset_result", res, 32'd12);
    check_int("post_reset_latency", lat, MUL_LAT);
    next_cycle();
    ex_md_valid = 1'b0;
    next_cycle();

    // randomized ops against the reference model
    for (int i = 0; i < 150; i++) begin
      f = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin
          a = $urandom_range(0, 20);
          b = $urandom_range(1, 9);
          if ($urandom_range(0, 1) == 1) a = -a;
          if ($urandom_range(0, 1) == 1) b = -b;
        end
        default: ;
      endcase
      run_op(f, a, b, res, lat, stall_ok);
      check32($sformatf("rand%0d_f%0d_%h_%h", i, f, a, b), res, ref_md(f, a, b));
      check_int($sformatf("rand%0d_latency", i), lat, ref_lat(f, a, b));
      next_cycle();
      if ($urandom_range(0, 1) == 1) begin
        ex_md_valid = 1'b0;
        next_cycle();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
